// File: rtl/serial_link_tx.sv
// Request-side serial link driver: buffers parallel words in a small FIFO and
// shifts each one out LSB-first on a/b, retrying unacknowledged words before dropping them.
module serial_link_tx #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_a,
    output logic             o_b,
    input  logic             i_c,
    input  logic             i_d,
    output logic             o_done,
    output logic             o_drop,
    output logic             o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ready;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic [BW-1:0]    r_bit_idx;
    logic [TW-1:0]    r_timer;
    logic [RW-1:0]    r_retry;

    logic             r_a;
    logic             r_b;
    logic             r_done;
    logic             r_drop;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [BW-1:0]    w_bit_idx_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [RW-1:0]    w_retry_nxt;
    logic             w_done_nxt;
    logic             w_drop_nxt;

    assign w_push = i_valid && r_ready;

    // FIFO occupancy for the next cycle
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, pointers and registered ready flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_COUNT);
        end
    end

    // Next-state and datapath decisions; an ack in the timeout cycle takes priority
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_bit_idx_nxt = r_bit_idx;
        w_timer_nxt   = r_timer;
        w_retry_nxt   = r_retry;
        w_pop         = 1'b0;
        w_done_nxt    = 1'b0;
        w_drop_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != CW'(0)) begin
                    w_pop         = 1'b1;
                    w_hold_nxt    = r_mem[r_rd_ptr];
                    w_bit_idx_nxt = BW'(0);
                    w_retry_nxt   = RW'(0);
                    w_state_nxt   = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (i_c) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_timer_nxt = TW'(0);
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BW'(1);
                    end
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_WAIT: begin
                if (i_d) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == LAST_TICK) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_nxt   = r_retry + RW'(1);
                        w_bit_idx_nxt = BW'(0);
                        w_state_nxt   = S_SHIFT;
                    end else begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and word-tracking registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_hold    <= {WIDTH{1'b0}};
            r_bit_idx <= BW'(0);
            r_timer   <= TW'(0);
            r_retry   <= RW'(0);
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_retry   <= w_retry_nxt;
        end
    end

    // Link outputs are registered from next-state so they line up with the SHIFT state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_done <= 1'b0;
            r_drop <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_a    <= (w_state_nxt == S_SHIFT);
            r_b    <= (w_state_nxt == S_SHIFT) ? w_hold_nxt[w_bit_idx_nxt] : 1'b0;
            r_done <= w_done_nxt;
            r_drop <= w_drop_nxt;
            r_busy <= (w_state_nxt != S_IDLE) || (w_count_nxt != CW'(0));
        end
    end

    assign o_ready = r_ready;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_done  = r_done;
    assign o_drop  = r_drop;
    assign o_busy  = r_busy;

endmodule
